// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control path: state encodings,
// opcode/funct constants, datapath select encodings and the control bundle.
package ctrl_defs;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_SLL   = 6'b000000;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_GPR    = 2'b11;

    localparam logic [1:0] DST_RT = 2'b00;
    localparam logic [1:0] DST_RD = 2'b01;
    localparam logic [1:0] DST_RA = 2'b10;

    localparam logic [1:0] WD_ALU  = 2'b00;
    localparam logic [1:0] WD_DMEM = 2'b01;
    localparam logic [1:0] WD_PC4  = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b010;

    localparam logic [1:0] EXT_ZERO = 2'b00;
    localparam logic [1:0] EXT_SIGN = 2'b01;
    localparam logic [1:0] EXT_LUI  = 2'b10;

    // One-hot instruction class bit positions
    localparam int CI_ADDU = 0;
    localparam int CI_SUBU = 1;
    localparam int CI_ORI  = 2;
    localparam int CI_LUI  = 3;
    localparam int CI_LW   = 4;
    localparam int CI_SW   = 5;
    localparam int CI_BEQ  = 6;
    localparam int CI_J    = 7;
    localparam int CI_JAL  = 8;
    localparam int CI_JR   = 9;
    localparam int CI_SLL  = 10;
    localparam int NUM_CLS = 11;

    typedef logic [NUM_CLS-1:0] cls_t;

    typedef struct packed {
        logic       ir_we;
        logic       pc_we;
        logic [1:0] pc_sel;
        logic       reg_we;
        logic [1:0] reg_dst;
        logic [1:0] wd_sel;
        logic       alu_src;
        logic [2:0] alu_op;
        logic [1:0] ext_op;
        logic       dm_re;
        logic       dm_we;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '0;

    // ALU/extender setup for a class; reused in EXEC, MEM and WB so the ALU
    // result stays stable until it is consumed.
    function automatic ctrl_t exec_ctl(input cls_t c);
        ctrl_t r;
        r = CTRL_IDLE;
        r.alu_src = c[CI_ORI] | c[CI_LUI] | c[CI_LW] | c[CI_SW];
        if (c[CI_SUBU] | c[CI_BEQ])
            r.alu_op = ALU_SUB;
        else if (c[CI_ORI] | c[CI_LUI])
            r.alu_op = ALU_OR;
        else
            r.alu_op = ALU_ADD;
        if (c[CI_LUI])
            r.ext_op = EXT_LUI;
        else if (c[CI_LW] | c[CI_SW])
            r.ext_op = EXT_SIGN;
        else
            r.ext_op = EXT_ZERO;
        return r;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_dec.sv
// Instruction class decoder: maps opcode/funct onto a one-hot class vector;
// no class bit set means the encoding is not supported.
module instr_class_dec
    import ctrl_defs::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funcode,
    output cls_t       cls,
    output logic       illegal
);

    always_comb begin
        cls = '0;
        case (opcode)
            OP_RTYPE: begin
                case (funcode)
                    FN_ADDU: cls[CI_ADDU] = 1'b1;
                    FN_SUBU: cls[CI_SUBU] = 1'b1;
                    FN_JR:   cls[CI_JR]   = 1'b1;
                    FN_SLL:  cls[CI_SLL]  = 1'b1;
                    default: cls          = '0;
                endcase
            end
            OP_ORI:  cls[CI_ORI] = 1'b1;
            OP_LUI:  cls[CI_LUI] = 1'b1;
            OP_LW:   cls[CI_LW]  = 1'b1;
            OP_SW:   cls[CI_SW]  = 1'b1;
            OP_BEQ:  cls[CI_BEQ] = 1'b1;
            OP_J:    cls[CI_J]   = 1'b1;
            OP_JAL:  cls[CI_JAL] = 1'b1;
            default: cls         = '0;
        endcase
    end

    assign illegal = ~|cls;

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences FETCH/DECODE/EXEC/MEM/WB with
// ready-handshaked memories and drives all datapath enables and selects.
module multicycle_ctrl
    import ctrl_defs::*;
#(
    parameter bit MEM_HANDSHAKE = 1'b1,
    parameter bit ILLEGAL_HALT  = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funcode,
    input  logic       zero,
    input  logic       imem_ready,
    input  logic       dmem_ready,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] pc_sel,
    output logic       reg_we,
    output logic [1:0] reg_dst,
    output logic [1:0] wd_sel,
    output logic       alu_src,
    output logic [2:0] alu_op,
    output logic [1:0] ext_op,
    output logic       dm_re,
    output logic       dm_we,
    output logic [2:0] state,
    output logic       illegal
);

    state_e state_q, state_d;
    logic   illegal_q, illegal_d;
    cls_t   cls;
    logic   cls_illegal;
    logic   imem_rdy, dmem_rdy;
    ctrl_t  ctl, ctl_out;

    instr_class_dec u_dec (
        .opcode  (opcode),
        .funcode (funcode),
        .cls     (cls),
        .illegal (cls_illegal)
    );

    assign imem_rdy = MEM_HANDSHAKE ? imem_ready : 1'b1;
    assign dmem_rdy = MEM_HANDSHAKE ? dmem_ready : 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        ctl       = CTRL_IDLE;
        unique case (state_q)
            S_FETCH: begin
                if (imem_rdy) begin
                    ctl.ir_we = 1'b1;
                    state_d   = S_DECODE;
                end
            end
            S_DECODE: begin
                if (cls_illegal) begin
                    illegal_d = 1'b1;
                    if (ILLEGAL_HALT) begin
                        state_d = S_HALT;
                    end else begin
                        ctl.pc_we  = 1'b1;
                        ctl.pc_sel = PC_PLUS4;
                        state_d    = S_FETCH;
                    end
                end else if (cls[CI_J]) begin
                    ctl.pc_we  = 1'b1;
                    ctl.pc_sel = PC_JUMP;
                    state_d    = S_FETCH;
                end else if (cls[CI_JAL]) begin
                    ctl.pc_we   = 1'b1;
                    ctl.pc_sel  = PC_JUMP;
                    ctl.reg_we  = 1'b1;
                    ctl.reg_dst = DST_RA;
                    ctl.wd_sel  = WD_PC4;
                    state_d     = S_FETCH;
                end else if (cls[CI_JR]) begin
                    ctl.pc_we  = 1'b1;
                    ctl.pc_sel = PC_GPR;
                    state_d    = S_FETCH;
                end else if (cls[CI_SLL]) begin
                    ctl.pc_we  = 1'b1;
                    ctl.pc_sel = PC_PLUS4;
                    state_d    = S_FETCH;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                ctl = exec_ctl(cls);
                if (cls[CI_BEQ]) begin
                    ctl.pc_we  = 1'b1;
                    ctl.pc_sel = zero ? PC_BRANCH : PC_PLUS4;
                    state_d    = S_FETCH;
                end else if (cls[CI_LW] | cls[CI_SW]) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                // The request stays up through the completing cycle; sw retires here.
                ctl = exec_ctl(cls);
                if (cls[CI_SW]) begin
                    ctl.dm_we = 1'b1;
                    if (dmem_rdy) begin
                        ctl.pc_we  = 1'b1;
                        ctl.pc_sel = PC_PLUS4;
                        state_d    = S_FETCH;
                    end
                end else begin
                    ctl.dm_re = 1'b1;
                    if (dmem_rdy)
                        state_d = S_WB;
                end
            end
            S_WB: begin
                ctl         = exec_ctl(cls);
                ctl.reg_we  = 1'b1;
                ctl.pc_we   = 1'b1;
                ctl.pc_sel  = PC_PLUS4;
                ctl.reg_dst = (cls[CI_ADDU] | cls[CI_SUBU]) ? DST_RD : DST_RT;
                ctl.wd_sel  = cls[CI_LW] ? WD_DMEM : WD_ALU;
                state_d     = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Outputs are combinational, so gate them with reset to kill any enable
    // in the same cycle reset is asserted rather than at the next edge.
    assign ctl_out = reset ? ctl : CTRL_IDLE;

    assign ir_we   = ctl_out.ir_we;
    assign pc_we   = ctl_out.pc_we;
    assign pc_sel  = ctl_out.pc_sel;
    assign reg_we  = ctl_out.reg_we;
    assign reg_dst = ctl_out.reg_dst;
    assign wd_sel  = ctl_out.wd_sel;
    assign alu_src = ctl_out.alu_src;
    assign alu_op  = ctl_out.alu_op;
    assign ext_op  = ctl_out.ext_op;
    assign dm_re   = ctl_out.dm_re;
    assign dm_we   = ctl_out.dm_we;
    assign state   = state_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: each issued instruction pushes its
// expected retirement record; a negedge monitor pops it on every pc_we pulse.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode, funcode;
    logic       zero, imem_ready, dmem_ready;
    logic       ir_we, pc_we, reg_we, alu_src, dm_re, dm_we, illegal;
    logic [1:0] pc_sel, reg_dst, wd_sel, ext_op;
    logic [2:0] alu_op, state;

    multicycle_ctrl dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funcode(funcode), .zero(zero),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .ir_we(ir_we), .pc_we(pc_we),
        .pc_sel(pc_sel), .reg_we(reg_we), .reg_dst(reg_dst), .wd_sel(wd_sel),
        .alu_src(alu_src), .alu_op(alu_op), .ext_op(ext_op), .dm_re(dm_re),
        .dm_we(dm_we), .state(state), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // Mnemonic indices
    localparam int M_ADDU = 0, M_SUBU = 1, M_ORI = 2, M_LUI = 3, M_LW = 4, M_SW = 5;
    localparam int M_BEQ = 6, M_J = 7, M_JAL = 8, M_JR = 9, M_SLL = 10;
    localparam logic [5:0] OPS [11] = '{6'h00, 6'h00, 6'h0D, 6'h0F, 6'h23, 6'h2B,
                                        6'h04, 6'h02, 6'h03, 6'h00, 6'h00};
    localparam logic [5:0] FNS [11] = '{6'h21, 6'h23, 6'h00, 6'h00, 6'h00, 6'h00,
                                        6'h00, 6'h00, 6'h00, 6'h08, 6'h00};
    localparam logic [5:0] NO_EXEC = 6'h3F;

    typedef struct {
        logic [1:0] pc_sel;
        logic       reg_we;
        logic [1:0] reg_dst;
        logic [1:0] wd_sel;
        int         lat;
        int         dmc;
        logic [5:0] exs;
        logic [5:0] exs_mask;
    } rec_t;

    rec_t exp_q[$];
    int   checks = 0, failures = 0;
    logic mon_en = 1'b0;
    int   mcyc, mdmc, nret;
    logic [5:0] mexs;

    function automatic logic [16:0] all_out();
        return {ir_we, pc_we, pc_sel, reg_we, reg_dst, wd_sel, alu_src, alu_op, ext_op, dm_re, dm_we};
    endfunction

    // Reference: what one instruction must look like when it retires.
    function automatic rec_t model(input int m, input logic z, input int wi, input int wd);
        rec_t e;
        e.pc_sel = 2'd0; e.reg_we = 1'b0; e.reg_dst = 2'd0; e.wd_sel = 2'd0;
        e.lat = wi; e.dmc = 0; e.exs = NO_EXEC; e.exs_mask = 6'h3F;
        case (m)
            M_ADDU: begin e.lat += 4; e.reg_we = 1; e.reg_dst = 2'd1; e.exs = 6'b0_000_00; e.exs_mask = 6'b111100; end
            M_SUBU: begin e.lat += 4; e.reg_we = 1; e.reg_dst = 2'd1; e.exs = 6'b0_001_00; e.exs_mask = 6'b111100; end
            M_ORI:  begin e.lat += 4; e.reg_we = 1; e.exs = 6'b1_010_00; end
            M_LUI:  begin e.lat += 4; e.reg_we = 1; e.exs = 6'b1_010_10; end
            M_LW:   begin e.lat += 5 + wd; e.reg_we = 1; e.wd_sel = 2'd1; e.dmc = wd + 1; e.exs = 6'b1_000_01; end
            M_SW:   begin e.lat += 4 + wd; e.dmc = wd + 1; e.exs = 6'b1_000_01; end
            M_BEQ:  begin e.lat += 3; e.pc_sel = z ? 2'd1 : 2'd0; e.exs = 6'b0_001_00; e.exs_mask = 6'b111100; end
            M_J:    begin e.lat += 2; e.pc_sel = 2'd2; end
            M_JAL:  begin e.lat += 2; e.pc_sel = 2'd2; e.reg_we = 1; e.reg_dst = 2'd2; e.wd_sel = 2'd2; end
            M_JR:   begin e.lat += 2; e.pc_sel = 2'd3; end
            default: e.lat += 2; // sll
        endcase
        return e;
    endfunction

    // Called at posedge+1 of the instruction's first FETCH cycle; returns at
    // posedge+1 of the next instruction's first cycle.
    task automatic issue(input int m, input logic z, input int wi, input int wd);
        rec_t e;
        e = model(m, z, wi, wd);
        exp_q.push_back(e);
        opcode  = OPS[m];
        funcode = (OPS[m] == 6'h00) ? FNS[m] : 6'($urandom);
        zero    = z;
        for (int k = 0; k < e.lat; k++) begin
            imem_ready = (k >= wi);
            dmem_ready = (k >= wi + 3 + wd);
            @(posedge clk); #1;
        end
    endtask

    always @(negedge clk) begin
        if (!reset || !mon_en) begin
            mcyc = 0; mdmc = 0; mexs = NO_EXEC;
        end else begin
            rec_t a, e;
            mcyc++;
            if (dm_re | dm_we) mdmc++;
            if (state == 3'd2) mexs = {alu_src, alu_op, ext_op};
            if (ir_we && state != 3'd0) begin
                failures++;
                $display("FAIL ir_we_outside_fetch: state=%0d", state);
            end
            if (reg_we && !pc_we) begin
                failures++;
                $display("FAIL stray_reg_we: state=%0d", state);
            end
            if (pc_we) begin
                checks++;
                nret++;
                a.pc_sel = pc_sel; a.reg_we = reg_we; a.reg_dst = reg_dst; a.wd_sel = wd_sel;
                a.lat = mcyc; a.dmc = mdmc; a.exs = mexs; a.exs_mask = 6'h3F;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_retire #%0d: no instruction outstanding", nret);
                end else begin
                    e = exp_q.pop_front();
                    if (a.pc_sel != e.pc_sel || a.reg_we != e.reg_we || a.lat != e.lat || a.dmc != e.dmc ||
                        (e.reg_we && (a.reg_dst != e.reg_dst || a.wd_sel != e.wd_sel)) ||
                        ((a.exs & e.exs_mask) != (e.exs & e.exs_mask))) begin
                        failures++;
                        $display("FAIL retire #%0d: got pc_sel=%0d reg_we=%0d reg_dst=%0d wd_sel=%0d lat=%0d dm=%0d exec=%b, want pc_sel=%0d reg_we=%0d reg_dst=%0d wd_sel=%0d lat=%0d dm=%0d exec=%b mask=%b",
                                 nret, a.pc_sel, a.reg_we, a.reg_dst, a.wd_sel, a.lat, a.dmc, a.exs,
                                 e.pc_sel, e.reg_we, e.reg_dst, e.wd_sel, e.lat, e.dmc, e.exs, e.exs_mask);
                    end
                end
                mcyc = 0; mdmc = 0; mexs = NO_EXEC;
            end
        end
    end

    task automatic check(input string name, input logic ok, input int got, input int want);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    initial begin
        logic bad;
        nret = 0;
        reset = 1'b0; opcode = 6'h23; funcode = 6'h00; zero = 1'b0;
        imem_ready = 1'b1; dmem_ready = 1'b1;
        #2;
        check("reset_outputs", all_out() == 17'd0, int'(all_out()), 0);
        check("reset_state", state == 3'd0 && illegal == 1'b0, int'(state), 0);

        // Release, then reset again while lw sits in EXEC.
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("first_ir_we", ir_we == 1'b1 && state == 3'd0, int'(ir_we), 1);
        @(posedge clk); @(posedge clk); #1;
        check("in_exec", state == 3'd2 && alu_src == 1'b1 && ext_op == 2'b01, int'(state), 2);
        #2 reset = 1'b0;
        #1;
        check("async_reset_state", state == 3'd0, int'(state), 0);
        check("async_reset_outputs", all_out() == 17'd0, int'(all_out()), 0);
        @(posedge clk); #1;
        reset = 1'b1;

        // Directed cases through the scoreboard, then random traffic.
        mon_en = 1'b1;
        issue(M_ADDU, 1'b0, 0, 0);
        issue(M_BEQ,  1'b1, 0, 0);
        issue(M_BEQ,  1'b0, 0, 0);
        issue(M_LW,   1'b0, 0, 3);
        issue(M_JAL,  1'b0, 0, 0);
        issue(M_SW,   1'b1, 2, 1);
        for (int i = 0; i < 150; i++)
            issue(int'($urandom_range(10, 0)), 1'($urandom), int'($urandom_range(3, 0)),
                  int'($urandom_range(3, 0)));
        check("scoreboard_drained", exp_q.size() == 0, exp_q.size(), 0);
        mon_en = 1'b0;

        // Illegal opcode halts and is sticky until reset.
        opcode = 6'h3F; funcode = 6'h00; imem_ready = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        check("halt_state", state == 3'd5, int'(state), 5);
        check("illegal_flag", illegal == 1'b1, int'(illegal), 1);
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (all_out() != 17'd0 || state != 3'd5) bad = 1'b1;
            imem_ready = 1'($urandom); dmem_ready = 1'($urandom); zero = 1'($urandom);
        end
        check("halt_quiet_20", bad == 1'b0, int'(bad), 0);
        reset = 1'b0;
        #1;
        check("halt_cleared_state", state == 3'd0, int'(state), 0);
        check("illegal_cleared", illegal == 1'b0, int'(illegal), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
